// File: rtl/gate_sweep_ctrl.sv
// Walks a combinational gate through every input code, samples its output after a
// programmable settle time and scores the captured truth table against a latched reference.
//
// state | meaning
// IDLE  | waiting for start; previous results stay readable
// RUN   | driving dut_in = idx, counting settle cycles, sampling on counter == 0
// DONE  | one-cycle done pulse; pass already registered
module gate_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  localparam int NCOMB = 1 << N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NCOMB-1:0]  expected,
  input  logic              dut_out,
  output logic [N_IN-1:0]   dut_in,
  output logic              busy,
  output logic              done,
  output logic [NCOMB-1:0]  result,
  output logic [N_IN:0]     err_count,
  output logic              pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [3:0]      SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST  = {N_IN{1'b1}};

  state_t           state_q;
  state_t           state_d;
  logic [N_IN-1:0]  idx_q;
  logic [3:0]       settle_q;
  logic [NCOMB-1:0] exp_q;
  logic             accept;
  logic             sample;
  logic             last;
  logic             mismatch;

  assign last     = (idx_q == IDX_LAST);
  assign mismatch = (dut_out != exp_q[idx_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    sample  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    dut_in  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        dut_in = idx_q;
        // abort outranks a coinciding sample edge, so that sample is dropped
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_q == 4'd0) begin
          sample = 1'b1;
          if (last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      settle_q  <= 4'd0;
      exp_q     <= '0;
      result    <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      exp_q     <= expected;
      result    <= '0;
      err_count <= '0;
      pass      <= 1'b0;
      idx_q     <= '0;
      settle_q  <= SETTLE_M1;
    end else if (state_q == S_RUN) begin
      if (abort) begin
        pass <= 1'b0;
      end else if (!sample) begin
        settle_q <= settle_q - 4'd1;
      end else begin
        result[idx_q] <= dut_out;
        if (mismatch) begin
          err_count <= err_count + 1'b1;
        end
        // pass must include the final sample, which is not yet in err_count
        if (last) begin
          pass <= (err_count == '0) && !mismatch;
        end else begin
          idx_q    <= idx_q + 1'b1;
          settle_q <= SETTLE_M1;
        end
      end
    end
  end

endmodule
